stage_sequencer: RTL

- Central control FSM for the non-pipelined MIPS core.
- Replaces the free-running 6-bit rotate counter with a sequencer that drives the one-hot stage vector consumed by fetch, decode, execute, mem_access and writeback.
- Adds run/halt control, single-step debug, a data-memory wait-state handshake, an optional MEM-stage skip, and retired-instruction/cycle counters.

---
 rtl/stage_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Central control sequencer for the non-pipelined MIPS core: drives the one-hot
// stage vector, run/halt/step control, data-memory wait handshake and counters.
module stage_sequencer #(
    parameter int SKIP_MEM = 1,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step,
    input  logic             mem_needed,
    input  logic             mem_ack,
    input  logic             halt_req,
    output logic [5:0]       state,
    output logic             mem_req,
    output logic             reg_we_en,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_PCUPD, S_PAUSE, S_HALTED
    } state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic               halt_pending_reg;
    logic               fault_reg;
    logic               timeout;
    logic               halt_now;
    logic               enter_halt;
    logic [5:0]         stage_vec_next;
    logic [5:0]         stage_vec_reg;
    logic               mem_req_reg, reg_we_en_reg, pc_we_reg, busy_reg, halted_reg;
    logic [CNT_W-1:0]   instr_count_reg, cycle_count_reg;

    // A halt request seen in the boundary cycle itself still stops at that boundary.
    assign halt_now   = halt_pending_reg | halt_req;
    assign enter_halt = (state_next == S_HALTED) && (state_reg != S_HALTED);

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            S_IDLE:    if (run && !fault_reg) state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = ((SKIP_MEM != 0) && !mem_needed) ? S_WB : S_MEM;
            S_MEM: begin
                if (mem_ack) begin
                    state_next = S_WB;
                end else if (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)) begin
                    state_next = S_HALTED;
                    timeout    = 1'b1;
                end
            end
            S_WB:      state_next = S_PCUPD;
            S_PCUPD: begin
                if (halt_now || !run) state_next = S_HALTED;
                else if (step_mode)   state_next = S_PAUSE;
                else                  state_next = S_FETCH;
            end
            S_PAUSE: begin
                if (!run || halt_now)      state_next = S_HALTED;
                else if (step || !step_mode) state_next = S_FETCH;
            end
            S_HALTED:  if (!run) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stage_vec_next = 6'b000000;
        case (state_next)
            S_FETCH:   stage_vec_next = 6'b000001;
            S_DECODE:  stage_vec_next = 6'b000010;
            S_EXECUTE: stage_vec_next = 6'b000100;
            S_MEM:     stage_vec_next = 6'b001000;
            S_WB:      stage_vec_next = 6'b010000;
            S_PCUPD:   stage_vec_next = 6'b100000;
            default:   stage_vec_next = 6'b000000;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            wait_cnt_reg     <= '0;
            halt_pending_reg <= 1'b0;
            fault_reg        <= 1'b0;
            instr_count_reg  <= '0;
            cycle_count_reg  <= '0;
            stage_vec_reg    <= 6'b000000;
            mem_req_reg      <= 1'b0;
            reg_we_en_reg    <= 1'b0;
            pc_we_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_MEM) && !mem_ack && !timeout)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;
            halt_pending_reg <= enter_halt ? 1'b0 : (halt_pending_reg | halt_req);
            if (timeout)
                fault_reg <= 1'b1;
            if (state_reg == S_PCUPD)
                instr_count_reg <= instr_count_reg + 1'b1;
            if (busy_reg)
                cycle_count_reg <= cycle_count_reg + 1'b1;
            stage_vec_reg <= stage_vec_next;
            mem_req_reg   <= (state_next == S_MEM);
            reg_we_en_reg <= (state_next == S_WB);
            pc_we_reg     <= (state_next == S_PCUPD);
            busy_reg      <= (stage_vec_next != 6'b000000);
            halted_reg    <= (state_next == S_HALTED);
        end
    end

    assign state       = stage_vec_reg;
    assign mem_req     = mem_req_reg;
    assign reg_we_en   = reg_we_en_reg;
    assign pc_we       = pc_we_reg;
    assign busy        = busy_reg;
    assign halted      = halted_reg;
    assign fault       = fault_reg;
    assign instr_count = instr_count_reg;
    assign cycle_count = cycle_count_reg;

endmodule
